// File: rtl/forwarding_scoreboard_if.sv
// ID-stage <-> bypass/hazard unit bundle. The ID side (master) drives decode
// info, RF read data and stage results; the scoreboard (slave) returns operands.
interface forwarding_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
);
  logic                      freeze;
  logic                      flush;
  logic                      id_valid;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic                      id_is_ecall;
  logic [4:0]                id_rd;
  logic [NUM_SRC*5-1:0]      src_addr;
  logic [NUM_SRC*XLEN-1:0]   rf_dout;
  logic [DEPTH*XLEN-1:0]     stage_result;
  logic [NUM_SRC*XLEN-1:0]   fwd_dout;
  logic                      hazard_stall;
  logic                      halt;

  modport master (
    output freeze, flush, id_valid, id_reg_write, id_is_load, id_is_ecall,
           id_rd, src_addr, rf_dout, stage_result,
    input  fwd_dout, hazard_stall, halt
  );

  modport slave (
    input  freeze, flush, id_valid, id_reg_write, id_is_load, id_is_ecall,
           id_rd, src_addr, rf_dout, stage_result,
    output fwd_dout, hazard_stall, halt
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Bypass/hazard unit beside ID: tracks in-flight writers EX..WB, forwards the
// youngest ready result per source channel, raises load-use stalls, ecall halt.

module fsb_lane #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3
) (
  input  logic [4:0]                  eff_i,
  input  logic [DEPTH-1:0]            v_i,
  input  logic [DEPTH-1:0]            ld_i,
  input  logic [DEPTH-1:0][4:0]       rd_i,
  input  logic [DEPTH-1:0][XLEN-1:0]  res_i,
  input  logic [XLEN-1:0]             rf_i,
  output logic [XLEN-1:0]             fwd_o,
  output logic                        stall_o
);
  // Walk oldest to youngest so the youngest match overrides everything older.
  always_comb begin
    fwd_o   = rf_i;
    stall_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_i[k] && (rd_i[k] == eff_i) && (eff_i != 5'd0)) begin
        if (!ld_i[k] || (k >= 1)) begin
          fwd_o   = res_i[k];
          stall_o = 1'b0;
        end else begin
          fwd_o   = rf_i;
          stall_o = 1'b1;
        end
      end
    end
  end
endmodule

module forwarding_scoreboard #(
  parameter int XLEN      = 32,
  parameter int NUM_SRC   = 2,
  parameter int DEPTH     = 3,
  parameter bit ECALL_EN  = 1'b1,
  parameter int HALT_CODE = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  forwarding_scoreboard_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } ent_t;

  ent_t [DEPTH-1:0]                ent_q, ent_d;
  logic [DEPTH-1:0]                ent_v, ent_ld;
  logic [DEPTH-1:0][4:0]           ent_rd;
  logic [DEPTH-1:0][XLEN-1:0]      res;
  logic [NUM_SRC-1:0][4:0]         eff;
  logic [NUM_SRC-1:0][XLEN-1:0]    fwd;
  logic [NUM_SRC-1:0]              stall_req;
  logic                            stall;

  assign res = bus.stage_result;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_v[k]  = ent_q[k].v;
      ent_rd[k] = ent_q[k].rd;
      ent_ld[k] = ent_q[k].ld;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) eff[i] = bus.src_addr[5*i +: 5];
    // ecall reads a7 (x17) through channel 0 regardless of the decoded rs1
    if (ECALL_EN && bus.id_is_ecall) eff[0] = 5'd17;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fsb_lane #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lane (
      .eff_i   (eff[i]),
      .v_i     (ent_v),
      .ld_i    (ent_ld),
      .rd_i    (ent_rd),
      .res_i   (res),
      .rf_i    (bus.rf_dout[XLEN*i +: XLEN]),
      .fwd_o   (fwd[i]),
      .stall_o (stall_req[i])
    );
  end

  assign stall            = bus.id_valid && !bus.flush && (|stall_req);
  assign bus.hazard_stall = stall;
  assign bus.fwd_dout     = fwd;

  always_comb begin
    ent_d = ent_q;
    if (!bus.freeze) begin
      for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
      if (stall || bus.flush || !bus.id_valid) begin
        ent_d[0] = '0;
      end else begin
        ent_d[0].v  = bus.id_reg_write && (bus.id_rd != 5'd0);
        ent_d[0].rd = bus.id_rd;
        ent_d[0].ld = bus.id_is_load;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  if (ECALL_EN) begin : g_halt
    logic halt_q, halt_d;
    always_comb begin
      halt_d = halt_q;
      if (!bus.freeze && bus.id_valid && bus.id_is_ecall && !bus.flush && !stall &&
          (fwd[0] == XLEN'(HALT_CODE)))
        halt_d = 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) halt_q <= 1'b0;
      else       halt_q <= halt_d;
    end
    assign bus.halt = halt_q;
  end else begin : g_no_halt
    assign bus.halt = 1'b0;
  end
endmodule
